// File: rtl/edge_capture_pkg.sv
// Shared definitions for the edge/event capture block: edge-mode encodings
// and the controller state type.
package edge_capture_pkg;

  // Per-channel edge mode, two bits per channel.
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Controller state shared by all channels.
  typedef enum logic {
    WARMUP = 1'b0,
    ARMED  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/edge_capture_channel.sv
// One capture channel: synchroniser chain, optional debounce filter
// (compiled in when DEBOUNCE_EN is defined), accepted level and the
// one-cycle rise/fall/edge pulses. edge_set_o is the next-cycle edge pulse,
// so the owner of the pending flag can set it on the same edge as edge_o.
module edge_capture_channel
  import edge_capture_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       data_i,
  input  logic [1:0] mode_i,
  input  logic       armed_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       edge_o,
  output logic       edge_set_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;
  logic                   accept;
  logic                   rise_en, fall_en;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   edge_q, edge_d;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous level input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input differs from the level;
  // accept on the DEBOUNCE_CYCLES-th one. Held at zero while warming up.
  always_comb begin
    cnt_d  = '0;
    accept = 1'b0;
    if (armed_i && (sync_w != level_q)) begin
      if (cnt_q == CNT_LAST) accept = 1'b1;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  // Without the filter the length has no effect; only its range is guarded.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_out_of_range
  end

  assign accept = armed_i && (sync_w != level_q);
`endif

  // Decode which accepted directions produce an edge pulse.
  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (mode_i)
      MODE_OFF:  begin rise_en = 1'b0; fall_en = 1'b0; end
      MODE_RISE: begin rise_en = 1'b1; fall_en = 1'b0; end
      MODE_FALL: begin rise_en = 1'b0; fall_en = 1'b1; end
      MODE_BOTH: begin rise_en = 1'b1; fall_en = 1'b1; end
      default:   begin rise_en = 1'b0; fall_en = 1'b0; end
    endcase
  end

  // Level tracking and pulse generation. While warming up the level follows
  // the value the synchroniser output takes on this edge, so the level and
  // the synchroniser agree when the block arms and no edge appears.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    edge_d  = 1'b0;
    if (!armed_i) begin
      level_d = sync_q[SYNC_STAGES-2];
    end else if (accept) begin
      level_d = sync_w;
      rise_d  = sync_w;
      fall_d  = !sync_w;
      edge_d  = (sync_w && rise_en) || (!sync_w && fall_en);
    end
  end

  // Level and pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      edge_q  <= edge_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign edge_o     = edge_q;
  assign edge_set_o = edge_d;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel edge/event capture top: warm-up controller, per-channel
// capture instances, sticky pending flags (write-1-to-clear, set wins) and
// the registered masked interrupt. Define DEBOUNCE_EN to compile in the
// per-channel debounce filter of DEBOUNCE_CYCLES cycles.
module edge_event_capture
  import edge_capture_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [CHANNELS-1:0]   data_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   pend_clr,
  input  logic [CHANNELS-1:0]   irq_mask,
  output logic                  armed,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   rise_pulse,
  output logic [CHANNELS-1:0]   fall_pulse,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);

  localparam int              WARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES - 1);

  ctrl_state_t         state_q, state_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic                armed_w;
  logic [CHANNELS-1:0] edge_set;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic                irq_q, irq_d;

  assign armed_w = (state_q == ARMED);

  // Controller state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= WARMUP;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Stay in WARMUP for SYNC_STAGES edges so the synchronisers fill, then arm.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      WARMUP: begin
        if (warm_cnt_q == WARM_LAST) begin
          state_d    = ARMED;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      ARMED:   state_d = ARMED;
      default: state_d = WARMUP;
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_capture_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .data_i    (data_in[g]),
      .mode_i    (mode[2*g+1 -: 2]),
      .armed_i   (armed_w),
      .level_o   (level[g]),
      .rise_o    (rise_pulse[g]),
      .fall_o    (fall_pulse[g]),
      .edge_o    (edge_pulse[g]),
      .edge_set_o(edge_set[g])
    );
  end

  // Pending flags: clear by strobe, a same-cycle edge overrides the clear;
  // irq is the masked OR of the flags, one cycle behind them.
  always_comb begin
    pending_d = (pending_q & ~pend_clr) | edge_set;
    irq_d     = |(pending_q & irq_mask);
  end

  // Pending and interrupt registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign armed   = armed_w;
  assign pending = pending_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture with an edge-history reference model
// compared on every falling clock edge, plus hand-computed spot checks.
// Works with and without DEBOUNCE_EN defined.
module tb_edge_event_capture;

  localparam int C = 8;
  localparam int S = 2;
`ifdef DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           resetn;
  logic [C-1:0]   data_in, pend_clr, irq_mask;
  logic [2*C-1:0] mode;
  logic           armed, irq;
  logic [C-1:0]   level, rise_pulse, fall_pulse, edge_pulse, pending;

  always #5 clk = ~clk;

  edge_event_capture #(
    .CHANNELS(C), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .resetn(resetn), .data_in(data_in), .mode(mode),
    .pend_clr(pend_clr), .irq_mask(irq_mask), .armed(armed), .level(level),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .edge_pulse(edge_pulse),
    .pending(pending), .irq(irq)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist_q holds data_in as sampled on each edge since reset release. The
  // synchroniser output seen on edge e is the sample from edge e-S; a change
  // is accepted once it has been seen on DB consecutive edges.
  logic [C-1:0] hist_q[$];
  int           e_m = 0;
  int           run_m[C];
  logic [C-1:0] lvl_m = '0, rise_m = '0, fall_m = '0, edge_m = '0, pend_m = '0;
  logic         irq_m = 1'b0, armed_m = 1'b0;
  logic [C-1:0] pre_s, post_s;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q.delete();
      e_m = 0;
      lvl_m = '0; rise_m = '0; fall_m = '0; edge_m = '0; pend_m = '0;
      irq_m = 1'b0; armed_m = 1'b0;
      for (int i = 0; i < C; i++) run_m[i] = 0;
    end else begin
      e_m++;
      hist_q.push_back(data_in);
      pre_s  = (e_m - S >= 1) ? hist_q[e_m-S-1] : '0;
      post_s = (e_m - S + 1 >= 1) ? hist_q[e_m-S] : '0;
      irq_m  = |(pend_m & irq_mask);
      rise_m = '0; fall_m = '0; edge_m = '0;
      if (e_m <= S) begin
        lvl_m = post_s;
        for (int i = 0; i < C; i++) run_m[i] = 0;
      end else begin
        for (int i = 0; i < C; i++) begin
          if (pre_s[i] != lvl_m[i]) begin
            run_m[i]++;
            if (run_m[i] == DB) begin
              run_m[i]  = 0;
              lvl_m[i]  = pre_s[i];
              rise_m[i] = pre_s[i];
              fall_m[i] = !pre_s[i];
              edge_m[i] = pre_s[i] ? mode[2*i] : mode[2*i+1];
            end
          end else begin
            run_m[i] = 0;
          end
        end
      end
      pend_m  = (pend_m & ~pend_clr) | edge_m;
      armed_m = (e_m >= S);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("armed", armed, armed_m);
    check("level", level, lvl_m);
    check("rise_pulse", rise_pulse, rise_m);
    check("fall_pulse", fall_pulse, fall_m);
    check("edge_pulse", edge_pulse, edge_m);
    check("pending", pending, pend_m);
    check("irq", irq, irq_m);
  end

  // ---------------- driver helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  int rc, fc;

  initial begin
    resetn   = 1'b0;
    data_in  = '1;
    mode     = '0;
    pend_clr = '0;
    irq_mask = '0;
    step(3);
    check("rst_armed", armed, 0);
    check("rst_level", level, 0);
    check("rst_pending", pending, 0);
    check("rst_irq", irq, 0);

    // Reset release with all inputs high: arms after S edges, no pulses.
    resetn = 1'b1;
    step(S - 1);
    check("warm_armed_low", armed, 0);
    step(1);
    check("warm_armed_high", armed, 1);
    check("warm_level", level, 8'hFF);
    step(3);
    check("warm_no_rise", rise_pulse, 0);
    check("warm_no_pending", pending, 0);

    // ch0,ch1 rising only; others both edges; all may interrupt.
    mode     = 16'b11_11_11_11_11_11_01_01;
    irq_mask = '1;

    // ch0: bring low (no edge in rising mode), then rise.
    data_in[0] = 1'b0;
    step(S + DB + 2);
    check("ch0_fall_no_pend", pending[0], 0);
    data_in[0] = 1'b1;
    step(S + DB - 1);
    check("ch0_rise_early", rise_pulse[0], 0);
    step(1);
    check("ch0_rise", rise_pulse[0], 1);
    check("ch0_edge", edge_pulse[0], 1);
    check("ch0_pend", pending[0], 1);
    check("ch0_irq_lag", irq, 0);
    step(1);
    check("ch0_rise_one_cycle", rise_pulse[0], 0);
    check("ch0_irq", irq, 1);

    // ch1 falling in rising mode: fall pulse only.
    data_in[1] = 1'b0;
    step(S + DB);
    check("ch1_fall", fall_pulse[1], 1);
    check("ch1_edge", edge_pulse[1], 0);
    step(1);
    check("ch1_pend", pending[1], 0);

    // Clear everything: pending drops on the next edge, irq one later.
    pend_clr = '1;
    step(1);
    pend_clr = '0;
    check("clr_pending", pending, 0);
    check("clr_irq_lag", irq, 1);
    step(1);
    check("clr_irq", irq, 0);

    // ch2 to low, then clear its pending.
    data_in[2] = 1'b0;
    step(S + DB + 2);
    pend_clr[2] = 1'b1;
    step(1);
    pend_clr = '0;
    step(1);
`ifdef DEBOUNCE_EN
    // Short high glitch must be rejected.
    data_in[2] = 1'b1;
    step(5);
    data_in[2] = 1'b0;
    step(S + DB + 4);
    check("glitch_level", level[2], 0);
    check("glitch_pend", pending[2], 0);
`endif
    // 10-cycle high pulse: exactly one rise and one fall.
    rc = 0;
    fc = 0;
    data_in[2] = 1'b1;
    for (int c = 0; c < 10 + 2 * (S + DB) + 4; c++) begin
      if (c == 10) data_in[2] = 1'b0;
      step(1);
      rc += int'(rise_pulse[2]);
      fc += int'(fall_pulse[2]);
    end
    check("pulse10_rises", rc, 1);
    check("pulse10_falls", fc, 1);
    check("pulse10_pend", pending[2], 1);
    pend_clr[2] = 1'b1;
    step(1);
    pend_clr = '0;
    step(1);

    // ch3: clear strobe on the same edge as the edge pulse, set wins.
    data_in[3] = 1'b0;
    step(S + DB - 1);
    pend_clr[3] = 1'b1;
    step(1);
    pend_clr = '0;
    check("coll_edge", edge_pulse[3], 1);
    check("coll_pend", pending[3], 1);
    step(1);
    check("coll_pend_held", pending[3], 1);
    check("coll_irq", irq, 1);
    pend_clr[3] = 1'b1;
    step(1);
    pend_clr = '0;
    check("clr3_pend", pending[3], 0);
    step(1);
    check("clr3_irq", irq, 0);

    // All channels toggle together: F1 -> 0E.
    data_in = 8'h0E;
    step(S + DB);
    check("multi_rise", rise_pulse, 8'h0E);
    check("multi_fall", fall_pulse, 8'hF1);
    check("multi_edge", edge_pulse, 8'hFE);
    check("multi_pend", pending, 8'hFE);
    check("multi_level", level, 8'h0E);

    // Reset in the middle of an acceptance window.
    data_in[4] = 1'b1;
    step(S + 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_armed", armed, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_pulses", {rise_pulse, fall_pulse, edge_pulse}, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_irq", irq, 0);
    step(2);
    resetn = 1'b1;
    step(S);
    check("rewarm_armed", armed, 1);
    check("rewarm_level", level, 8'h1E);
    step(S + DB + 3);
    check("rewarm_no_pend", pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
